// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU control path: opcode field values
// and the control FSM state set.
package cpu_pkg;

   typedef enum logic [2:0] {
      OP_HLT = 3'b000,
      OP_SKZ = 3'b001,
      OP_ADD = 3'b010,
      OP_AND = 3'b011,
      OP_XOR = 3'b100,
      OP_LDA = 3'b101,
      OP_STO = 3'b110,
      OP_JMP = 3'b111
   } opcode_e;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   localparam state_e RESET_STATE = ST_FETCH;

endpackage

// File: rtl/cpu_control.sv
// Control FSM for the accumulator CPU: sequences fetch/decode/execute/writeback,
// drives datapath strobes as a combinational decode, and counts retired instructions.
module cpu_control
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       opcode,
   input  logic             acc_zero,
   input  logic             mem_ready,
   input  logic             run,
   output logic             sel_pc,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             ir_load,
   output logic             acc_load,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   state_e  state;
   state_e  state_nx;
   opcode_e op;
   logic    retire;

   assign op = opcode_e'(opcode);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RESET_STATE;
         retired <= '0;
      end else begin
         state <= state_nx;
         if (retire) begin
            retired <= retired + CNT_W'(1);
         end
      end
   end

   // sel_pc idles at PC; only operand accesses steer it to the IR address field
   always_comb begin
      state_nx = state;
      retire   = 1'b0;
      sel_pc   = 1'b1;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      ir_load  = 1'b0;
      acc_load = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      halted   = 1'b0;

      case (state)
         ST_FETCH: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               state_nx = ST_DECODE;
            end
         end

         ST_DECODE: begin
            ir_load  = 1'b1;
            pc_inc   = 1'b1;
            state_nx = ST_EXEC;
         end

         ST_EXEC: begin
            case (op)
               OP_HLT: begin
                  state_nx = ST_HALT;
                  retire   = 1'b1;
               end
               OP_SKZ: begin
                  pc_inc   = acc_zero;
                  state_nx = ST_FETCH;
                  retire   = 1'b1;
               end
               OP_JMP: begin
                  pc_load  = 1'b1;
                  state_nx = ST_FETCH;
                  retire   = 1'b1;
               end
               OP_STO: begin
                  sel_pc = 1'b0;
                  mem_wr = 1'b1;
                  if (mem_ready) begin
                     state_nx = ST_FETCH;
                     retire   = 1'b1;
                  end
               end
               default: begin
                  // ADD, AND, XOR, LDA: operand read, result captured in WB
                  sel_pc = 1'b0;
                  mem_rd = 1'b1;
                  if (mem_ready) begin
                     state_nx = ST_WB;
                  end
               end
            endcase
         end

         ST_WB: begin
            sel_pc   = 1'b0;
            mem_rd   = 1'b1;
            acc_load = 1'b1;
            state_nx = ST_FETCH;
            retire   = 1'b1;
         end

         ST_HALT: begin
            halted = 1'b1;
            if (run) begin
               state_nx = ST_FETCH;
            end
         end

         default: begin
            state_nx = ST_FETCH;
         end
      endcase
   end

endmodule
